// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory side of the cache miss path. It serves line fills and evictions after a fixed access latency.
// Defining MEM_RANGE_CHK_EN adds the MEM_LINES parameter and the mem_err pulse for out-of-range line addresses.
//
// state      | meaning
// S_IDLE     | waiting for mem_write / mem_read; the only state that samples requests
// S_WAIT     | access latency countdown
// S_RD_BURST | streaming one line out on rdata, one word per cycle
// S_WR_BURST | absorbing one line from wdata, one word per cycle
// S_DONE     | one-cycle completion pulse (plus mem_err on a range fault)
module mem_line_responder #(
    parameter int LINE_ADDR_W    = 8,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 3
`ifdef MEM_RANGE_CHK_EN
    ,
    parameter int MEM_LINES      = 2**LINE_ADDR_W
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [LINE_ADDR_W-1:0]            line_addr,
    input  logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              rdata_valid,
    output logic                              wr_ready,
    output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
    output logic                              busy,
    output logic                              mem_done
`ifdef MEM_RANGE_CHK_EN
    ,
    output logic                              mem_err
`endif
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 2**(LINE_ADDR_W + IDX_W);
    localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_DONE
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           op_write;
    logic [LINE_ADDR_W-1:0]         addr_q;
    logic [LAT_W-1:0]               lat_cnt;
    logic [IDX_W-1:0]               idx_cnt;
    logic                           addr_bad;
    logic [LINE_ADDR_W+IDX_W-1:0]   mem_addr;
    logic [DATA_W-1:0]              mem [DEPTH];

`ifdef MEM_RANGE_CHK_EN
    logic err_q;
    assign addr_bad = (32'(line_addr) >= 32'(MEM_LINES));
`else
    assign addr_bad = 1'b0;
`endif

    assign mem_addr = {addr_q, idx_cnt};

    // Both requests high: the eviction goes first and the read waits for the next IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mem_write || mem_read) begin
                    if (addr_bad)
                        state_nxt = S_DONE;
                    else if (LATENCY == 0)
                        state_nxt = mem_write ? S_WR_BURST : S_RD_BURST;
                    else
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0)
                    state_nxt = op_write ? S_WR_BURST : S_RD_BURST;
            end
            S_RD_BURST, S_WR_BURST: begin
                if (idx_cnt == LAST_IDX)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_write <= 1'b0;
            addr_q   <= '0;
            lat_cnt  <= '0;
            idx_cnt  <= '0;
`ifdef MEM_RANGE_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            // Request fields are captured every IDLE cycle; only the accepting cycle's copy survives.
            if (state == S_IDLE) begin
                op_write <= mem_write;
                addr_q   <= line_addr;
                lat_cnt  <= LAT_LOAD;
`ifdef MEM_RANGE_CHK_EN
                err_q    <= addr_bad;
`endif
            end else if (state == S_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            // Power-of-two line length makes the beat counter wrap back to 0 on exit.
            if (state == S_RD_BURST || state == S_WR_BURST)
                idx_cnt <= idx_cnt + 1'b1;
        end
    end

    // Backing array is never cleared; a reset edge blocks the write in flight.
    always_ff @(posedge clk) begin
        if (!rst && state == S_WR_BURST)
            mem[mem_addr] <= wdata;
    end

    always_comb begin
        rdata       = '0;
        rdata_valid = 1'b0;
        wr_ready    = 1'b0;
        word_idx    = '0;
        busy        = 1'b0;
        mem_done    = 1'b0;
`ifdef MEM_RANGE_CHK_EN
        mem_err     = 1'b0;
`endif
        if (!rst) begin
            busy     = (state != S_IDLE);
            mem_done = (state == S_DONE);
            wr_ready = (state == S_WR_BURST);
            word_idx = idx_cnt;
            if (state == S_RD_BURST) begin
                rdata_valid = 1'b1;
                rdata       = mem[mem_addr];
            end
`ifdef MEM_RANGE_CHK_EN
            mem_err = (state == S_DONE) && err_q;
`endif
        end
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a LATENCY=3 instance and a LATENCY=0 instance checked cycle by cycle
// against a timing-formula reference and an associative-array memory model.
module tb_mem_line_responder;

    localparam int LAW   = 8;
    localparam int DW    = 32;
    localparam int W     = 4;
    localparam int IW    = 2;
    localparam int LAT_A = 3;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           req_read = 1'b0;
    logic           req_write = 1'b0;
    logic           sel0 = 1'b0;
    logic [LAW-1:0] line_addr = '0;
    logic [DW-1:0]  wdata = '0;

    logic           rd_a, wr_req_a, rd_b, wr_req_b;
    logic [DW-1:0]  rdata_a, rdata_b;
    logic           rv_a, rv_b, wrr_a, wrr_b, busy_a, busy_b, done_a, done_b;
    logic [IW-1:0]  idx_a, idx_b;

    logic [DW-1:0]  o_rdata;
    logic           o_rv, o_wr, o_busy, o_done;
    logic [IW-1:0]  o_idx;

    assign rd_a     = req_read  & ~sel0;
    assign wr_req_a = req_write & ~sel0;
    assign rd_b     = req_read  &  sel0;
    assign wr_req_b = req_write &  sel0;

    assign o_rdata = sel0 ? rdata_b : rdata_a;
    assign o_rv    = sel0 ? rv_b    : rv_a;
    assign o_wr    = sel0 ? wrr_b   : wrr_a;
    assign o_busy  = sel0 ? busy_b  : busy_a;
    assign o_done  = sel0 ? done_b  : done_a;
    assign o_idx   = sel0 ? idx_b   : idx_a;

`ifdef MEM_RANGE_CHK_EN
    logic err_a, err_b, o_err;
    assign o_err = sel0 ? err_b : err_a;
`endif

    mem_line_responder #(
        .LINE_ADDR_W(LAW), .DATA_W(DW), .WORDS_PER_LINE(W), .LATENCY(LAT_A)
`ifdef MEM_RANGE_CHK_EN
        , .MEM_LINES(200)
`endif
    ) dut_a (
        .clk(clk), .rst(rst), .mem_read(rd_a), .mem_write(wr_req_a),
        .line_addr(line_addr), .wdata(wdata), .rdata(rdata_a),
        .rdata_valid(rv_a), .wr_ready(wrr_a), .word_idx(idx_a),
        .busy(busy_a), .mem_done(done_a)
`ifdef MEM_RANGE_CHK_EN
        , .mem_err(err_a)
`endif
    );

    mem_line_responder #(
        .LINE_ADDR_W(LAW), .DATA_W(DW), .WORDS_PER_LINE(W), .LATENCY(LAT_B)
    ) dut_b (
        .clk(clk), .rst(rst), .mem_read(rd_b), .mem_write(wr_req_b),
        .line_addr(line_addr), .wdata(wdata), .rdata(rdata_b),
        .rdata_valid(rv_b), .wr_ready(wrr_b), .word_idx(idx_b),
        .busy(busy_b), .mem_done(done_b)
`ifdef MEM_RANGE_CHK_EN
        , .mem_err(err_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: key = instance*4096 + line*W + word.
    logic [DW-1:0] model [int];
    int wq_a [$];
    int wq_b [$];

    function automatic int mkey(input bit s, input logic [LAW-1:0] a, input int i);
        return (s ? 4096 : 0) + int'(a) * W + i;
    endfunction

    // One full transaction starting from IDLE; cycle k after acceptance is predicted from
    // latency/line-length arithmetic alone: k<=lat wait, then W beats, then the done cycle.
    task automatic run_op(input bit s, input bit wr, input bit also_rd, input bit keep_rd,
                          input logic [LAW-1:0] a, input bit jitter, input bit fixed,
                          input logic [DW-1:0] base, input string tag);
        int lat, last, drop_k, key;
        logic [3:0] exp_flags, got_flags;
        logic [IW-1:0] exp_idx;
        lat    = s ? LAT_B : LAT_A;
        last   = lat + W + 1;
        drop_k = jitter ? int'($urandom_range(1, last - 1)) : 0;
        @(negedge clk);
        sel0 = s;
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_busy got=%b want=0", tag, o_busy);
        end
        req_write = wr;
        req_read  = !wr || also_rd;
        line_addr = a;
        wdata     = $urandom;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            exp_flags = 4'b1000;
            exp_idx   = '0;
            if (k > lat && k <= lat + W) begin
                exp_idx = IW'(k - lat - 1);
                if (wr) exp_flags[1] = 1'b1;
                else    exp_flags[2] = 1'b1;
            end
            if (k == last) exp_flags[0] = 1'b1;
            got_flags = {o_busy, o_rv, o_wr, o_done};
            total++;
            if (got_flags !== exp_flags || o_idx !== exp_idx) begin
                bad++;
                $display("FAIL %s cycle%0d busy/rv/wr/done/idx got=%b/%0d want=%b/%0d",
                         tag, k, got_flags, o_idx, exp_flags, exp_idx);
            end
            key = mkey(s, a, int'(exp_idx));
            if (!wr && exp_flags[2] && model.exists(key)) begin
                total++;
                if (o_rdata !== model[key]) begin
                    bad++;
                    $display("FAIL %s rdata word%0d got=%h want=%h", tag, exp_idx, o_rdata, model[key]);
                end
            end
`ifdef MEM_RANGE_CHK_EN
            total++;
            if (o_err !== 1'b0) begin
                bad++;
                $display("FAIL %s mem_err cycle%0d got=%b want=0", tag, k, o_err);
            end
`endif
            if (wr && exp_flags[1]) begin
                wdata = fixed ? base + DW'(exp_idx) : $urandom;
                model[key] = wdata;
            end else begin
                wdata = $urandom;
            end
            if (jitter) line_addr = LAW'($urandom);
            if (k == drop_k) begin
                req_write = 1'b0;
                req_read  = 1'b0;
            end
            if (k == last) begin
                req_write = 1'b0;
                req_read  = keep_rd;
            end
        end
        if (wr) begin
            if (s) wq_b.push_back(int'(a));
            else   wq_a.push_back(int'(a));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({rdata_a, rv_a, wrr_a, idx_a, busy_a, done_a, rdata_b, rv_b, wrr_b, idx_b, busy_b, done_b} !== '0) begin
                bad++;
                $display("FAIL reset_outputs phase%0d a=%h/%b%b%b%b%b b=%h/%b%b%b%b%b want all 0", c,
                         rdata_a, rv_a, wrr_a, busy_a, done_a, idx_a[0], rdata_b, rv_b, wrr_b, busy_b, done_b, idx_b[0]);
            end
            if (c == 1) rst = 1'b0;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
                bad++;
                $display("FAIL idle_busy cycle%0d got=%b%b want=00", c, busy_a, busy_b);
            end
        end
    endtask

    task automatic test_write_read();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 32'hA0, "wr05");
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, '0, "rd05");
    endtask

    task automatic test_latency_zero();
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 32'hB0, "lat0_wr");
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, '0, "lat0_rd");
    endtask

    task automatic test_simultaneous();
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, '0, "both_wr");
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, '0, "both_rd");
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] got;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, '0, "pre_wr44");
        @(negedge clk);
        sel0 = 1'b0;
        req_write = 1'b1;
        line_addr = 8'h44;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                total++;
                if (o_wr !== 1'b1 || o_idx !== IW'(k - 4)) begin
                    bad++;
                    $display("FAIL abort_beat%0d wr/idx got=%b/%0d want=1/%0d", k - 4, o_wr, o_idx, k - 4);
                end
                wdata = (k == 4) ? 32'h11 : 32'h22;
                model[mkey(1'b0, 8'h44, k - 4)] = wdata;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        req_write = 1'b0;
        wdata = 32'hDEAD_BEEF;
        #1;
        got = {o_busy, o_rv, o_wr, o_done};
        total++;
        if (got !== 4'b0000 || o_idx !== '0) begin
            bad++;
            $display("FAIL abort_rst_high busy/rv/wr/done/idx got=%b/%0d want=0000/0", got, o_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got = {o_busy, o_rv, o_wr, o_done};
        total++;
        if (got !== 4'b0000 || o_idx !== '0 || o_rdata !== '0) begin
            bad++;
            $display("FAIL abort_after busy/rv/wr/done/idx/rdata got=%b/%0d/%h want=0000/0/0", got, o_idx, o_rdata);
        end
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, '0, "rd44_after_abort");
    endtask

    task automatic test_random_ops();
        bit s, wr;
        logic [LAW-1:0] a;
        for (int n = 0; n < 30; n++) begin
            s  = 1'($urandom_range(0, 1));
            wr = ((s ? wq_b.size() : wq_a.size()) == 0) || ($urandom_range(0, 1) == 1);
            if (wr)     a = LAW'($urandom_range(0, 199));
            else if (s) a = LAW'(wq_b[$urandom_range(0, wq_b.size() - 1)]);
            else        a = LAW'(wq_a[$urandom_range(0, wq_a.size() - 1)]);
            run_op(s, wr, 1'b0, 1'b0, a, 1'b1, 1'b0, '0, "rand");
        end
    endtask

`ifdef MEM_RANGE_CHK_EN
    task automatic test_range_check();
        logic [4:0] got;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, '0, "rc_wr10");
        @(negedge clk);
        sel0 = 1'b0;
        req_read = 1'b1;
        line_addr = 8'hF0;
        @(negedge clk);
        got = {o_busy, o_rv, o_wr, o_done, o_err};
        total++;
        if (got !== 5'b10011) begin
            bad++;
            $display("FAIL range_err busy/rv/wr/done/err got=%b want=10011", got);
        end
        req_read = 1'b0;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, '0, "rc_rd10");
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_latency_zero();
        test_simultaneous();
        test_reset_mid_burst();
        test_random_ops();
`ifdef MEM_RANGE_CHK_EN
        test_range_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Main-memory side of the cache miss path: responds to line-fill (read) and line-eviction (write) requests issued by the cache control FSM.
- Owns a word-addressed backing array organised as lines of WORDS_PER_LINE words.
- Inserts a programmable access latency, then streams one line word-by-word, one word per cycle.
- Signals completion with a one-cycle done pulse.

Parameters:
- LINE_ADDR_W, 8, line address width; the array holds 2**LINE_ADDR_W lines.
- DATA_W, 32, word width.
- WORDS_PER_LINE, 4, words per cache line; power of two, ≥2.
- LATENCY, 3, wait cycles between request acceptance and the first data beat; 0 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_read  in  1  line-fill request; held until mem_done.
- mem_write  in  1  line-eviction request; held until mem_done.
- line_addr  in  LINE_ADDR_W  line address; sampled at acceptance.
- wdata  in  DATA_W  eviction word; must be valid in every cycle wr_ready=1.
- rdata  out  DATA_W  fill word; valid when rdata_valid=1.
- rdata_valid  out  1  fill beat strobe.
- wr_ready  out  1  eviction beat strobe; wdata is written at the edge ending this cycle.
- word_idx  out  log2(WORDS_PER_LINE)  index of the current beat.
- busy  out  1  request in progress (any state other than IDLE).
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle error pulse; exists only with MEM_RANGE_CHK_EN.

Behaviour:
- Reset: if rst=1 at a rising edge, the FSM goes to IDLE and both counters clear. All outputs are 0 while rst is high and in the first cycle after it (rdata=0, word_idx=0). Reset wins over every other event, including mid-burst. Array contents are not cleared. Words already written by an aborted eviction stay written.
- States: IDLE, WAIT, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Requests are sampled only here.
  - mem_write=1 → accept, latch line_addr and op=write.
  - Else mem_read=1 → accept, op=read.
  - If both are high, write wins (eviction precedes allocation). The read must stay asserted; it is accepted after the following DONE→IDLE.
  - On acceptance, go to WAIT, or straight to the burst state if LATENCY=0.
- WAIT: latency counter runs 1..LATENCY. On the LATENCY-th cycle the next state is RD_BURST or WR_BURST according to the latched op.
- RD_BURST:
  - Lasts WORDS_PER_LINE cycles.
  - rdata_valid=1 throughout.
  - rdata = array[{latched_addr, word_idx}], combinational from the array.
  - word_idx counts 0..WORDS_PER_LINE-1 and wraps to 0 on exit.
- WR_BURST:
  - Lasts WORDS_PER_LINE cycles.
  - wr_ready=1 throughout.
  - Each edge writes wdata into array[{latched_addr, word_idx}].
  - word_idx counts as in RD_BURST.
- DONE: one cycle, mem_done=1, busy=1. Next state is IDLE.
- Timing: acceptance edge E0 → beats in cycles E0+LATENCY+1 .. E0+LATENCY+WORDS_PER_LINE. DONE is the following cycle. A new request can be accepted one cycle after DONE.
- Request inputs and line_addr changing while busy are ignored. Dropping the request mid-operation does not abort it.
- Outputs are decoded from registered state and counters. There are no combinational paths from request inputs to outputs.

Optional Feature:
- Macro: MEM_RANGE_CHK_EN. Adds a parameter MEM_LINES (default 2**LINE_ADDR_W) and the mem_err port.
- With the macro: if the request accepted in IDLE has line_addr ≥ MEM_LINES:
  - WAIT and burst are skipped; the next state is DONE.
  - In DONE, mem_done=1 and mem_err=1 in the same cycle.
  - No array access, no beats.
- Without the macro: no mem_err port, no check. All addresses map to the array modulo its size.

Test Plan:
- Reset then idle: assert rst 2 cycles → all outputs 0. With no request, busy stays 0 for 10 cycles.
- Write then read back (defaults): mem_write, line_addr=0x05, wdata=0xA0,0xA1,0xA2,0xA3 on the wr_ready beats (cycles E0+4..E0+7), mem_done at E0+8. Then mem_read at 0x05 → rdata_valid in 4 cycles with rdata 0xA0..0xA3, word_idx 0..3, mem_done pulse once.
- Simultaneous request: mem_read=mem_write=1 in IDLE → WR_BURST occurs first. After mem_done, with mem_read still high, the read is accepted on the next IDLE cycle.
- LATENCY=0 build: mem_read accepted at E0 → rdata_valid at E0+1..E0+4, mem_done at E0+5.
- Reset mid-eviction: rst after 2 write beats (0x11, 0x22) → IDLE next cycle with all outputs 0. A later read of that line returns 0x11, 0x22, then the prior contents of words 2 and 3.
- MEM_RANGE_CHK_EN, MEM_LINES=200: mem_read at line_addr=0xF0 → mem_err=mem_done=1 at E0+1, no rdata_valid. A read at 0x10 completes normally.
